id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage pipeline; directly downstream of the register file.
- Captures decoded operands and control from ID into registered EX-stage signals.
- Detects load-use hazards and inserts bubbles.
- Applies a same-cycle WB→ID write bypass.
- Honours EX back-pressure (hold) and branch flush.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
XLEN, 64, operand/PC/immediate width
CNT_W, 32, width of bubble counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a valid instruction
id_pc  input  XLEN  instruction PC
id_rs1, id_rs2, id_rd  input  5  register specifiers
id_use_rs1, id_use_rs2  input  1  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data  input  XLEN  register-file read data
id_imm  input  XLEN  sign-extended immediate
id_reg_write, id_mem_read, id_mem_write, id_alu_src  input  1  control bits
id_alu_op  input  4  ALU operation
wb_reg_write  input  1  WB writes register file this cycle
wb_rd  input  5  WB destination
wb_data  input  XLEN  WB write data
ex_stall  input  1  EX cannot accept (multi-cycle op); hold contents
flush  input  1  branch redirect; kill instruction entering/in EX
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  output  1  registered
ex_alu_op  output  4  registered
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered
ex_rs1, ex_rs2, ex_rd  output  5  registered
hazard_stall  output  1  combinational; IF and ID must hold
bubble_count  output  CNT_W  registered, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - Every registered output is cleared to 0 (ex_valid=0, all data/control=0, bubble_count=0).
  - Reset overrides all other inputs.
  - A reset asserted mid-stall discards the held instruction.
- Load-use detection (combinational):
  - lu = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - hazard_stall = (lu | ex_stall) & ~flush.
- WB bypass (combinational, applied at capture):
  - op1 = (wb_reg_write & wb_rd≠0 & wb_rd==id_rs1) ? wb_data : id_rs1_data; op2 likewise for rs2.
  - x0 never bypassed.
- Posedge update priority (first match wins):
  1. rst: clear all.
  2. flush: ex_valid←0 and all control bits←0; data fields don't-care (implemented as cleared). Flush wins over ex_stall and lu.
  3. ex_stall: hold all registers, with one exception: if ex_valid & wb_reg_write & wb_rd≠0, refresh ex_rs1_data←wb_data when wb_rd==ex_rs1, and ex_rs2_data←wb_data when wb_rd==ex_rs2. This keeps held operands coherent.
  4. lu: insert bubble (ex_valid←0, control bits←0, data cleared); bubble_count increments.
  5. else: capture ID fields. ex_valid←id_valid; control bits forced 0 when id_valid=0; operands from the bypass.
- Latency: exactly 1 cycle ID→EX; no internal buffering beyond one entry.
- bubble_count:
  - Increments only on a lu bubble (case 4).
  - Saturates at all-ones; never wraps.
  - Cleared only by rst.
- Invalid (ex_valid=0) EX contents never trigger lu.
- Identical rs1==rs2 matching a load rd counts as a single bubble.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with random ID inputs → all ex_* = 0, bubble_count=0, hazard_stall=0.
- Load-use: cycle0 ID lw x5 (mem_read, rd=5) captured; cycle1 ID add x6,x5,x1 (use_rs1) → hazard_stall=1, next ex_valid=0, bubble_count=1; cycle2 add captured, ex_rs1=5.
- No false hazard: ex load rd=0, or id_use_rs2=0 with id_rs2==ex_rd=7 → hazard_stall=0, instruction captured, bubble_count unchanged.
- WB bypass: id_rs1=3, id_rs1_data=0x11, wb_reg_write=1, wb_rd=3, wb_data=0xDEAD → ex_rs1_data=0xDEAD. Same with wb_rd=0 → ex_rs1_data=0x11.
- Stall hold/refresh: ex_stall=1 for 3 cycles with ex_rs2=9; WB writes x9=0x42 in cycle 2 → all fields held except ex_rs2_data=0x42; hazard_stall=1 throughout.
- Flush priority: flush=1 together with ex_stall=1 and lu=1 → next ex_valid=0, ex_reg_write=0, hazard_stall=0, bubble_count unchanged. Separately, force 2^CNT_W−1 bubbles (CNT_W=4 override) → bubble_count stays at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage pipeline.
//
// Captures decoded operands and control from ID into registered EX-stage signals.
// It also handles these hazards and controls:
//   - Load-use hazards: a bubble is inserted into EX and hazard_stall holds IF/ID.
//   - WB->ID bypass: a register-file write in the same cycle is forwarded at capture.
//   - EX back-pressure (ex_stall): the current entry is held.
//   - Branch flush: the instruction entering or sitting in EX is killed.
// bubble_count counts load-use bubbles and saturates at all-ones.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   id_*                decoded instruction from ID (valid, pc, specifiers, operands, control)
//   wb_reg_write/rd/data  register-file write happening this cycle
//   ex_stall            EX cannot accept; hold contents
//   flush               branch redirect; kill EX entry
//   ex_*                registered EX-stage instruction
//   hazard_stall        combinational; IF and ID must hold
//   bubble_count        registered saturating load-use bubble counter
module id_ex_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic [3:0]       id_alu_op,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic [3:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_count
);

    logic             valid_q, valid_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             alu_src_q, alu_src_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    logic             lu;
    logic             wb_live;
    logic [XLEN-1:0]  op1, op2;

    // Only a valid load in EX can create a load-use hazard.
    always_comb begin
        lu = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
             ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
    end

    assign hazard_stall = (lu | ex_stall) & ~flush;

    // Writes to x0 are never forwarded.
    assign wb_live = wb_reg_write & (wb_rd != 5'd0);
    assign op1     = (wb_live & (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
    assign op2     = (wb_live & (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

    always_comb begin
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        alu_src_d      = alu_src_q;
        alu_op_d       = alu_op_q;
        pc_d           = pc_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        imm_d          = imm_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        bubble_count_d = bubble_count_q;

        if (flush || (!ex_stall && lu)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            alu_src_d   = 1'b0;
            alu_op_d    = '0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            if (!flush && (bubble_count_q != '1)) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else if (ex_stall) begin
            // A held instruction must see writebacks that land while it waits.
            if (valid_q && wb_live) begin
                if (wb_rd == rs1_q) rs1_data_d = wb_data;
                if (wb_rd == rs2_q) rs2_data_d = wb_data;
            end
        end else begin
            valid_d     = id_valid;
            reg_write_d = id_valid & id_reg_write;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
            alu_src_d   = id_valid & id_alu_src;
            alu_op_d    = id_valid ? id_alu_op : 4'd0;
            pc_d        = id_pc;
            rs1_data_d  = op1;
            rs2_data_d  = op2;
            imm_d       = id_imm;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            alu_src_q      <= 1'b0;
            alu_op_q       <= '0;
            pc_q           <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            alu_src_q      <= alu_src_d;
            alu_op_q       <= alu_op_d;
            pc_q           <= pc_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_alu_src   = alu_src_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of per-cycle vectors, then hand-written
// sequences for stall hold/refresh, reset mid-stall, and counter saturation (CNT_W=4 copy).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        ex_stall, flush;

    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        hazard_stall;
    logic [31:0] bubble_count;

    logic        s_valid, s_reg_write, s_mem_read, s_mem_write, s_alu_src;
    logic [3:0]  s_alu_op;
    logic [63:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_hazard_stall;
    logic [3:0]  s_bubble_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    // Narrow-counter copy driven by the same stimulus, for saturation checks.
    id_ex_stage #(.XLEN(64), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(s_valid), .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read),
        .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src), .ex_alu_op(s_alu_op),
        .ex_pc(s_pc), .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data),
        .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
        .hazard_stall(s_hazard_stall), .bubble_count(s_bubble_count)
    );

    typedef struct {
        logic        rst, vld;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [63:0] d1, d2;
        logic        mr, rw, wbe;
        logic [4:0]  wbrd;
        logic [63:0] wbd;
        logic        stall, fl;
        logic        e_hz, e_v, e_rw, e_mr;
        logic [4:0]  e_rs1, e_rd;
        logic [63:0] e_d1, e_d2;
        logic [31:0] e_bc;
    } vec_t;

    function automatic vec_t mk(
        input int unsigned r, input int unsigned vl, input int unsigned a1,
        input int unsigned a2, input int unsigned ad, input int unsigned u1,
        input int unsigned u2, input logic [63:0] d1, input logic [63:0] d2,
        input int unsigned mr, input int unsigned rw, input int unsigned we,
        input int unsigned wrd, input logic [63:0] wd, input int unsigned st,
        input int unsigned fl, input int unsigned hz, input int unsigned ev,
        input int unsigned erw, input int unsigned emr, input int unsigned ers1,
        input int unsigned erd, input logic [63:0] ed1, input logic [63:0] ed2,
        input int unsigned ebc);
        vec_t v;
        v.rst = (r != 0);    v.vld = (vl != 0);
        v.rs1 = 5'(a1);      v.rs2 = 5'(a2);      v.rd = 5'(ad);
        v.use1 = (u1 != 0);  v.use2 = (u2 != 0);
        v.d1 = d1;           v.d2 = d2;
        v.mr = (mr != 0);    v.rw = (rw != 0);    v.wbe = (we != 0);
        v.wbrd = 5'(wrd);    v.wbd = wd;
        v.stall = (st != 0); v.fl = (fl != 0);
        v.e_hz = (hz != 0);  v.e_v = (ev != 0);
        v.e_rw = (erw != 0); v.e_mr = (emr != 0);
        v.e_rs1 = 5'(ers1);  v.e_rd = 5'(erd);
        v.e_d1 = ed1;        v.e_d2 = ed2;        v.e_bc = ebc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_id(input logic vld, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [4:0] ad, input logic u1, input logic u2,
                            input logic [63:0] d1, input logic [63:0] d2,
                            input logic mr, input logic rw);
        id_valid = vld; id_rs1 = a1; id_rs2 = a2; id_rd = ad;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2;
        id_mem_read = mr; id_reg_write = rw;
    endtask

    vec_t vt[19];

    initial begin
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        id_pc = 64'h1000; id_imm = 64'd0; id_mem_write = 1'b0; id_alu_src = 1'b0;
        id_alu_op = 4'd0; wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
        repeat (2) @(posedge clk);

        //          rst vld rs1 rs2 rd u1 u2 d1 d2 mr rw wbe wbrd wbd st fl
        //          | hz v rw mr ers1 erd ed1 ed2 bc
        vt[0]  = mk(1, 1, 5, 6, 7, 1, 1, 'hAAAA, 'hBBBB, 1, 1, 1, 5, 'h77, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 3, 4, 9, 1, 0, 'h1234, 'h5678, 0, 1, 1, 3, 'h99, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(0, 1, 1, 0, 5, 1, 0, 'h100, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 1, 1, 5, 'h100, 0, 0);
        vt[3]  = mk(0, 1, 5, 1, 6, 1, 1, 'h55, 'h66, 0, 1, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[4]  = mk(0, 1, 5, 1, 6, 1, 1, 'h55, 'h66, 0, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 0, 5, 6, 'h55, 'h66, 1);
        vt[5]  = mk(0, 1, 2, 0, 0, 1, 0, 'h200, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 1, 2, 0, 'h200, 0, 1);
        vt[6]  = mk(0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 0, 0, 8, 0, 0, 1);
        vt[7]  = mk(0, 1, 3, 0, 7, 1, 0, 'h300, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 1, 3, 7, 'h300, 0, 1);
        vt[8]  = mk(0, 1, 4, 7, 9, 1, 0, 'h44, 'h99, 0, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 0, 4, 9, 'h44, 'h99, 1);
        vt[9]  = mk(0, 1, 3, 2, 10, 1, 1, 'h11, 'h22, 0, 1, 1, 3, 'hDEAD, 0, 0,
                    0, 1, 1, 0, 3, 10, 'hDEAD, 'h22, 1);
        vt[10] = mk(0, 1, 0, 2, 10, 1, 1, 'h11, 'h22, 0, 1, 1, 0, 'hDEAD, 0, 0,
                    0, 1, 1, 0, 0, 10, 'h11, 'h22, 1);
        vt[11] = mk(0, 1, 1, 12, 11, 1, 1, 'h1, 'h22, 0, 1, 1, 12, 'hBEEF, 0, 0,
                    0, 1, 1, 0, 1, 11, 'h1, 'hBEEF, 1);
        vt[12] = mk(0, 0, 1, 0, 5, 1, 0, 'h123, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 1, 5, 'h123, 0, 1);
        vt[13] = mk(0, 1, 5, 0, 6, 1, 0, 'h5, 0, 0, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 0, 5, 6, 'h5, 0, 1);
        vt[14] = mk(0, 1, 1, 0, 9, 1, 0, 'h1, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 1, 1, 9, 'h1, 0, 1);
        vt[15] = mk(0, 1, 9, 9, 10, 1, 1, 'h91, 'h92, 0, 1, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 0, 0, 2);
        vt[16] = mk(0, 1, 9, 9, 10, 1, 1, 'h91, 'h92, 0, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 0, 9, 10, 'h91, 'h92, 2);
        vt[17] = mk(0, 1, 2, 0, 11, 1, 0, 'h2, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 1, 1, 1, 2, 11, 'h2, 0, 2);
        vt[18] = mk(0, 1, 11, 0, 12, 1, 0, 'h7, 0, 0, 1, 0, 0, 0, 1, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, 2);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            drive_id(vt[i].vld, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].use1, vt[i].use2,
                     vt[i].d1, vt[i].d2, vt[i].mr, vt[i].rw);
            wb_reg_write = vt[i].wbe; wb_rd = vt[i].wbrd; wb_data = vt[i].wbd;
            ex_stall = vt[i].stall; flush = vt[i].fl;
            #1;
            chk("hazard_stall", i, 64'(hazard_stall), 64'(vt[i].e_hz));
            @(posedge clk); #1;
            chk("ex_valid", i, 64'(ex_valid), 64'(vt[i].e_v));
            chk("ex_reg_write", i, 64'(ex_reg_write), 64'(vt[i].e_rw));
            chk("ex_mem_read", i, 64'(ex_mem_read), 64'(vt[i].e_mr));
            chk("ex_rs1", i, 64'(ex_rs1), 64'(vt[i].e_rs1));
            chk("ex_rd", i, 64'(ex_rd), 64'(vt[i].e_rd));
            chk("ex_rs1_data", i, ex_rs1_data, vt[i].e_d1);
            chk("ex_rs2_data", i, ex_rs2_data, vt[i].e_d2);
            chk("bubble_count", i, 64'(bubble_count), 64'(vt[i].e_bc));
        end

        // Stall hold/refresh: capture an instruction, then hold it 3 cycles.
        @(negedge clk);
        rst = 1'b0; ex_stall = 1'b0; flush = 1'b0; wb_reg_write = 1'b0;
        drive_id(1'b1, 5'd8, 5'd9, 5'd13, 1'b1, 1'b1, 64'h81, 64'h91, 1'b0, 1'b1);
        id_pc = 64'h2000; id_imm = 64'h33; id_alu_op = 4'd5;
        id_mem_write = 1'b1; id_alu_src = 1'b1;
        @(posedge clk); #1;
        chk("cap_pc", 0, ex_pc, 64'h2000);
        chk("cap_imm", 0, ex_imm, 64'h33);
        chk("cap_alu_op", 0, 64'(ex_alu_op), 64'd5);
        chk("cap_mem_write", 0, 64'(ex_mem_write), 64'd1);
        chk("cap_alu_src", 0, 64'(ex_alu_src), 64'd1);
        chk("cap_rs2", 0, 64'(ex_rs2), 64'd9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 64'hAA, 64'hBB, 1'b1, 1'b1);
            id_pc = 64'h3000; id_imm = 64'h44; id_alu_op = 4'd7;
            ex_stall = 1'b1;
            wb_reg_write = (k == 1); wb_rd = 5'd9; wb_data = 64'h42;
            #1;
            chk("stall_hazard", k, 64'(hazard_stall), 64'd1);
            @(posedge clk); #1;
            chk("stall_valid", k, 64'(ex_valid), 64'd1);
            chk("stall_pc", k, ex_pc, 64'h2000);
            chk("stall_rs1", k, 64'(ex_rs1), 64'd8);
            chk("stall_rd", k, 64'(ex_rd), 64'd13);
            chk("stall_alu_op", k, 64'(ex_alu_op), 64'd5);
            chk("stall_rs1_data", k, ex_rs1_data, 64'h81);
            chk("stall_rs2_data", k, ex_rs2_data, (k >= 1) ? 64'h42 : 64'h91);
            chk("stall_bubbles", k, 64'(bubble_count), 64'd2);
        end

        // Reset while stalled discards the held instruction.
        @(negedge clk);
        wb_reg_write = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_stall_valid", 0, 64'(ex_valid), 64'd0);
        chk("rst_stall_pc", 0, ex_pc, 64'd0);
        chk("rst_stall_rs2_data", 0, ex_rs2_data, 64'd0);
        chk("rst_stall_alu_op", 0, 64'(ex_alu_op), 64'd0);
        chk("rst_stall_bubbles", 0, 64'(bubble_count), 64'd0);

        // Load/dependent pairs: one bubble per pair; narrow counter saturates at 15.
        @(negedge clk);
        rst = 1'b0; ex_stall = 1'b0;
        id_pc = 64'h1000; id_imm = 64'd0; id_alu_op = 4'd0;
        id_mem_write = 1'b0; id_alu_src = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 64'h10, 64'd0, 1'b1, 1'b1);
            @(posedge clk);
            @(negedge clk);
            drive_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 64'h20, 64'd0, 1'b0, 1'b1);
            @(posedge clk); #1;
            chk("bubbles_wide", n, 64'(bubble_count), 64'(n));
            chk("bubbles_sat", n, 64'(s_bubble_count), (n > 15) ? 64'd15 : 64'(n));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
